// File: rtl/booth_mult_seq.sv
// booth_mult_seq
// ----------------------------------------------------------------------------
// Sequential radix-2 Booth multiplier. One add/subtract plus arithmetic shift
// per clock; operands are accepted on a valid/ready handshake and the product
// is presented on a second valid/ready handshake.
//
// Optional feature macro: BOOTH_UNSIGNED_EN
//   defined   -> adds the is_signed port; operands are widened by one bit at
//                load (sign- or zero-extended) and N = DATA_WIDTH+1.
//   undefined -> operands are always two's complement and N = DATA_WIDTH.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   in_valid      operand pair on m/q is valid
//   in_ready      block can accept operands (IDLE only)
//   m, q          multiplicand / multiplier
//   out_valid     final_result holds a completed product
//   out_ready     downstream consumes the result
//   final_result  2*DATA_WIDTH product
//   busy          operation in flight (RUN or DONE)
//   is_signed     (BOOTH_UNSIGNED_EN only) 1 = signed operands, 0 = unsigned
// ----------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     m,
    input  logic [DATA_WIDTH-1:0]     q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   final_result,
    output logic                      busy
`ifdef BOOTH_UNSIGNED_EN
    ,
    input  logic                      is_signed
`endif
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int N = DATA_WIDTH + 1;
`else
    localparam int N = DATA_WIDTH;
`endif
    localparam int W     = N;
    localparam int CNT_W = $clog2(N + 1);
    localparam int RES_W = 2 * DATA_WIDTH;
    // Top bit of A that still lands inside the low RES_W bits of {A, Q}.
    localparam int AHI   = RES_W - W - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [W:0]       a_q,         a_d;
    logic [W-1:0]     qr_q,        qr_d;
    logic             qm1_q,       qm1_d;
    logic [W:0]       m_q,         m_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [RES_W-1:0] res_q,       res_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [W-1:0]     m_ext_s;
    logic [W-1:0]     q_ext_s;
    logic [W:0]       sum_s;
    logic [W:0]       a_shift_s;
    logic [W-1:0]     q_shift_s;
    logic [RES_W-1:0] res_next_s;

    // Operand widening applied at the accept edge.
`ifdef BOOTH_UNSIGNED_EN
    assign m_ext_s = {is_signed & m[DATA_WIDTH-1], m};
    assign q_ext_s = {is_signed & q[DATA_WIDTH-1], q};
`else
    assign m_ext_s = m;
    assign q_ext_s = q;
`endif

    // Booth recoding of {Q[0], q_minus_one}: subtract, add or keep M.
    always_comb begin
        case ({qr_q[0], qm1_q})
            2'b10:   sum_s = a_q - m_q;
            2'b01:   sum_s = a_q + m_q;
            default: sum_s = a_q;
        endcase
    end

    // Arithmetic right shift of {A, Q, q_minus_one}; A's sign bit is replicated.
    assign a_shift_s  = {sum_s[W], sum_s[W:1]};
    assign q_shift_s  = {sum_s[0], qr_q[W-1:1]};
    assign res_next_s = {a_shift_s[AHI:0], q_shift_s};

    // FSM and datapath next-state; handshake outputs follow the next state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = {(W+1){1'b0}};
                    qr_d    = q_ext_s;
                    qm1_d   = 1'b0;
                    m_d     = {m_ext_s[W-1], m_ext_s};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_shift_s;
                qr_d  = q_shift_s;
                qm1_d = qr_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    res_d   = res_next_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
    end

    // State registers with synchronous reset; in_ready stays low through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {(W+1){1'b0}};
            qr_q        <= {W{1'b0}};
            qm1_q       <= 1'b0;
            m_q         <= {(W+1){1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            res_q       <= {RES_W{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            qr_q        <= qr_d;
            qm1_q       <= qm1_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign final_result = res_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases at DATA_WIDTH=8 and
// randomized handshake regressions at DATA_WIDTH=8 and 16 against a plain
// arithmetic reference multiply.
module tb_booth_mult_seq;

`ifdef BOOTH_UNSIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int N8 = 8 + EXTRA;

    logic        clk;
    logic        rst;
    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] res8;
    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] m16, q16;
    logic [31:0] res16;
`ifdef BOOTH_UNSIGNED_EN
    logic        iss8, iss16;
`endif

    int vectors;
    int miscompares;

    booth_mult_seq #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .m(m8), .q(q8),
        .out_valid(ov8), .out_ready(or8), .final_result(res8), .busy(busy8)
`ifdef BOOTH_UNSIGNED_EN
        , .is_signed(iss8)
`endif
    );

    booth_mult_seq #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .m(m16), .q(q16),
        .out_valid(ov16), .out_ready(or16), .final_result(res16), .busy(busy16)
`ifdef BOOTH_UNSIGNED_EN
        , .is_signed(iss16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the w-bit operands as signed or unsigned integers,
    // multiply, and keep the low 2*w bits.
    function automatic longint unsigned ref_prod(input longint unsigned a, input longint unsigned b,
                                                 input int w, input bit sgn);
        longint sa, sb, p;
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a & mask);
        sb = longint'(b & mask);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return longint'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One 8-bit operation: accept, count latency, hold out_ready low for
    // 'hold' cycles while offering new operands, then consume.
    task automatic do_op8(input logic [7:0] mv, input logic [7:0] qv, input bit sg,
                          input int hold, input string tag,
                          output logic [15:0] res, output int lat);
        int k;
        k = 0;
        while (!ir8 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_in_ready_before"}, 64'(ir8), 64'd1);
        m8 = mv;
        q8 = qv;
`ifdef BOOTH_UNSIGNED_EN
        iss8 = sg;
`endif
        iv8 = 1'b1;
        or8 = (hold == 0);
        lat = -1;
        do begin
            @(negedge clk);
            iv8 = 1'b0;
            m8  = 8'($urandom);
            q8  = 8'($urandom);
`ifdef BOOTH_UNSIGNED_EN
            iss8 = ~sg;
`endif
            lat++;
        end while (!ov8 && lat < 200);
        res = res8;
        chk({tag, "_latency"}, 64'(lat), 64'(N8));
        for (int h = 0; h < hold; h++) begin
            iv8 = 1'b1;
            m8  = 8'h11;
            q8  = 8'h22;
            @(negedge clk);
            chk({tag, "_hold_result"}, 64'(res8), 64'(res));
            chk({tag, "_hold_valid"}, 64'(ov8), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(ir8), 64'd0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        chk({tag, "_consumed"}, 64'(ov8), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(ir8), 64'd1);
        or8 = 1'b0;
    endtask

    // Random handshake regression on one of the two instances.
    task automatic rand_run(input int sel, input int count, input string tag);
        longint unsigned exp_q[$];
        longint unsigned cm, cq, robs;
        bit pend, cs, orr, ir, ov;
        int acc, got, cyc, w;
        pend = 1'b0; cs = 1'b1; cm = 64'd0; cq = 64'd0;
        acc = 0; got = 0; cyc = 0;
        w = (sel == 0) ? 8 : 16;
        while ((acc < count || exp_q.size() != 0) && cyc < count * 80) begin
            @(negedge clk);
            cyc++;
            ir   = (sel == 0) ? ir8 : ir16;
            ov   = (sel == 0) ? ov8 : ov16;
            robs = (sel == 0) ? 64'(res8) : 64'(res16);
            orr  = ($urandom_range(0, 3) != 0);
            if (!pend && acc < count && $urandom_range(0, 2) != 0) begin
                cm = 64'($urandom);
                cq = 64'($urandom);
                if ($urandom_range(0, 7) == 0) cm = 64'd1 << (w - 1);
                if ($urandom_range(0, 7) == 0) cq = (64'd1 << (w - 1)) - 64'd1;
                if ($urandom_range(0, 9) == 0) cq = 64'hFFFF_FFFF;
`ifdef BOOTH_UNSIGNED_EN
                cs = 1'($urandom_range(0, 1));
`endif
                pend = 1'b1;
            end
            if (sel == 0) begin
                iv8 = pend;
                m8  = pend ? cm[7:0] : 8'($urandom);
                q8  = pend ? cq[7:0] : 8'($urandom);
                or8 = orr;
`ifdef BOOTH_UNSIGNED_EN
                iss8 = cs;
`endif
            end else begin
                iv16 = pend;
                m16  = pend ? cm[15:0] : 16'($urandom);
                q16  = pend ? cq[15:0] : 16'($urandom);
                or16 = orr;
`ifdef BOOTH_UNSIGNED_EN
                iss16 = cs;
`endif
            end
            if (ov && orr) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_result"}, robs, 64'hDEAD);
                end else begin
                    chk({tag, "_product"}, robs, exp_q.pop_front());
                end
                got++;
            end
            if (pend && ir) begin
                exp_q.push_back(ref_prod(cm, cq, w, cs));
                acc++;
                pend = 1'b0;
            end
        end
        chk({tag, "_accepted"}, 64'(acc), 64'(count));
        chk({tag, "_results"}, 64'(got), 64'(count));
        if (sel == 0) begin
            iv8 = 1'b0; or8 = 1'b0;
        end else begin
            iv16 = 1'b0; or16 = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] r;
        int lat;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; m8 = 8'h00; q8 = 8'h00;
        iv16 = 1'b0; or16 = 1'b0; m16 = 16'h0000; q16 = 16'h0000;
`ifdef BOOTH_UNSIGNED_EN
        iss8 = 1'b1; iss16 = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(ir8), 64'd0);
        chk("reset_out_valid", 64'(ov8), 64'd0);
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_result", 64'(res8), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(ir8), 64'd1);
        chk("post_reset_busy", 64'(busy8), 64'd0);

        do_op8(8'd3, 8'hFC, 1'b1, 0, "m3_qm4", r, lat);
        chk("m3_qm4_result", 64'(r), 64'hFFF4);

        do_op8(8'h80, 8'h80, 1'b1, 0, "min_min", r, lat);
        chk("min_min_result", 64'(r), 64'h4000);
        do_op8(8'h80, 8'h7F, 1'b1, 0, "min_max", r, lat);
        chk("min_max_result", 64'(r), 64'hC080);

        do_op8(8'd7, 8'd9, 1'b1, 5, "backpressure", r, lat);
        chk("backpressure_result", 64'(r), 64'h003F);

        // Reset in the middle of an operation.
        m8 = 8'd5; q8 = 8'd5; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_busy", 64'(busy8), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_out_valid", 64'(ov8), 64'd0);
        chk("midrun_rst_busy", 64'(busy8), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_after_in_ready", 64'(ir8), 64'd1);
        chk("midrun_after_out_valid", 64'(ov8), 64'd0);
        or8 = 1'b0;
        do_op8(8'd2, 8'hFD, 1'b1, 0, "after_reset", r, lat);
        chk("after_reset_result", 64'(r), 64'hFFFA);

`ifdef BOOTH_UNSIGNED_EN
        do_op8(8'hFF, 8'hFF, 1'b0, 0, "unsigned_ff", r, lat);
        chk("unsigned_ff_result", 64'(r), 64'hFE01);
        do_op8(8'hFF, 8'hFF, 1'b1, 0, "signed_ff", r, lat);
        chk("signed_ff_result", 64'(r), 64'h0001);
`endif

        rand_run(0, 1500, "rand8");
        rand_run(1, 600, "rand16");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
